ntt_sdf_reorder: RTL and testbench

- Output reorder buffer that sits directly downstream of the last SDF NTT stage (stage LOGN-1). It consumes that stage's stage_out stream and re-emits each N=2**LOGN coefficient frame in natural order.
- Ping-pong memory: while one bank fills with frame k, the other bank drains frame k-1.
- A per-frame bypass keeps the incoming order, for dataflows whose last stage already emits natural order.

---
 rtl/ntt_sdf_reorder.sv | 144 ++++++++++++++
 tb/tb_ntt_sdf_reorder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sdf_reorder.sv
// Ping-pong output reorder buffer for the last SDF NTT stage: fills one bank in
// bit-reversed (or natural) order while the other bank drains in natural order.
module ntt_sdf_reorder #(
    parameter int LOGQ       = 0,
    parameter int LOGN       = 0,
    parameter int DELAY_BRAM = 1,
    localparam int QW        = (LOGQ > 0) ? LOGQ : 1,
    localparam int AW        = (LOGN > 0) ? LOGN : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bypass,
    input  logic [QW-1:0] stage_in,
    output logic [QW-1:0] stage_out,
    output logic          valid_out,
    output logic          frame_first,
    output logic          frame_last,
    output logic          busy
);

    localparam int            DEPTH    = 2 << AW;
    localparam int            PD       = DELAY_BRAM + 1;
    localparam logic [AW-1:0] LAST_IDX = '1;

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r;
    endfunction

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          byp_q, byp_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_active_q, rd_active_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          byp_eff;
    logic [AW-1:0] wr_addr;
    logic          frame_done;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        wr_cnt_d    = wr_cnt_q;
        byp_d       = byp_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_active_d = rd_active_q;
        rd_cnt_d    = rd_cnt_q;
        byp_eff     = (wr_cnt_q == '0) ? bypass : byp_q;
        wr_addr     = byp_eff ? wr_cnt_q : bit_rev(wr_cnt_q);
        frame_done  = start && (wr_cnt_q == LAST_IDX);

        if (start) begin
            wr_cnt_d = wr_cnt_q + AW'(1);
            if (wr_cnt_q == '0) byp_d = bypass;
        end

        if (rd_active_q) begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_cnt_q == LAST_IDX) rd_active_d = 1'b0;
        end

        // A completion landing on the final read restarts the drain with no bubble.
        if (frame_done) begin
            wr_bank_d   = ~wr_bank_q;
            rd_bank_d   = wr_bank_q;
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q    <= '0;
            byp_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            byp_q       <= byp_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_active_q <= rd_active_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    logic [QW-1:0] mem_q [DEPTH];

    // NOTE: the banks carry no reset so they can map onto block RAM; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (start) mem_q[{wr_bank_q, wr_addr}] <= stage_in;
    end

    logic [QW-1:0] dat_pipe_q [PD];
    logic [PD-1:0] vld_pipe_q, fst_pipe_q, lst_pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PD; i++) dat_pipe_q[i] <= '0;
            vld_pipe_q <= '0;
            fst_pipe_q <= '0;
            lst_pipe_q <= '0;
        end else begin
            dat_pipe_q[0] <= mem_q[{rd_bank_q, rd_cnt_q}];
            vld_pipe_q[0] <= rd_active_q;
            fst_pipe_q[0] <= rd_active_q && (rd_cnt_q == '0);
            lst_pipe_q[0] <= rd_active_q && (rd_cnt_q == LAST_IDX);
            for (int i = 1; i < PD; i++) begin
                dat_pipe_q[i] <= dat_pipe_q[i-1];
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                fst_pipe_q[i] <= fst_pipe_q[i-1];
                lst_pipe_q[i] <= lst_pipe_q[i-1];
            end
        end
    end

    logic [QW-1:0] stage_out_q;
    logic          valid_out_q, frame_first_q, frame_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_out_q   <= '0;
            valid_out_q   <= 1'b0;
            frame_first_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            if (vld_pipe_q[PD-1]) stage_out_q <= dat_pipe_q[PD-1];
            valid_out_q   <= vld_pipe_q[PD-1];
            frame_first_q <= fst_pipe_q[PD-1];
            frame_last_q  <= lst_pipe_q[PD-1];
        end
    end

    assign stage_out   = stage_out_q;
    assign valid_out   = valid_out_q;
    assign frame_first = frame_first_q;
    assign frame_last  = frame_last_q;
    assign busy        = (wr_cnt_q != '0) || rd_active_q || (|vld_pipe_q) || valid_out_q;

endmodule

// File: tb/tb_ntt_sdf_reorder.sv
// Directed bench for ntt_sdf_reorder: two instances (DELAY_BRAM=1 and 2) share stimulus;
// outputs are collected one step after each rising edge and compared against hand-derived orders.
module tb_ntt_sdf_reorder;

    localparam int LOGQ = 16;
    localparam int LOGN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bypass;
    logic [15:0] stage_in;
    logic [15:0] so1, so2;
    logic        v1, v2, f1, f2, l1, l2, b1, b2;

    always #5 clk = ~clk;

    ntt_sdf_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bypass(bypass), .stage_in(stage_in),
        .stage_out(so1), .valid_out(v1), .frame_first(f1), .frame_last(l1), .busy(b1)
    );

    ntt_sdf_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bypass(bypass), .stage_in(stage_in),
        .stage_out(so2), .valid_out(v2), .frame_first(f2), .frame_last(l2), .busy(b2)
    );

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
        int          cyc;
    } out_t;

    out_t q1[$];
    out_t q2[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   br[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic step(input logic s, input logic b, input logic [15:0] d);
        start    = s;
        bypass   = b;
        stage_in = d;
        @(posedge clk);
        #1;
        cyc++;
        if (v1) q1.push_back('{so1, f1, l1, cyc});
        if (v2) q2.push_back('{so2, f2, l2, cyc});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'hDEAD);
    endtask

    task automatic test_reset;
        checks++; if (so1 !== 16'd0) begin errors++; $display("FAIL reset_stage_out: got %0d want 0", so1); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v1); end
        checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL reset_first: got %b want 0", f1); end
        checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", l1); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b1); end
        checks++; if ({v2, b2} !== 2'b00) begin errors++; $display("FAIL reset_dut2: got valid/busy %b want 00", {v2, b2}); end
    endtask

    task automatic test_reorder;
        int c_last;
        q1.delete(); q2.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i));
        c_last = cyc;
        idle(12);
        checks++;
        if (q1.size() !== 8) begin errors++; $display("FAIL reorder_count: got %0d want 8", q1.size()); end
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            checks++;
            if (q1[i].data !== 16'(br[i]) || q1[i].first !== (i == 0) || q1[i].last !== (i == 7) || q1[i].cyc !== c_last + 3 + i) begin
                errors++;
                $display("FAIL reorder[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q1[i].data, q1[i].first, q1[i].last, q1[i].cyc, br[i], i == 0, i == 7, c_last + 3 + i);
            end
        end
    endtask

    task automatic test_bypass;
        int c_last;
        q1.delete(); q2.delete();
        step(1'b1, 1'b1, 16'd10);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 16'(10 + i));
        c_last = cyc;
        idle(12);
        checks++;
        if (q1.size() !== 8) begin errors++; $display("FAIL bypass_count: got %0d want 8", q1.size()); end
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            checks++;
            if (q1[i].data !== 16'(10 + i) || q1[i].first !== (i == 0) || q1[i].last !== (i == 7) || q1[i].cyc !== c_last + 3 + i) begin
                errors++;
                $display("FAIL bypass[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q1[i].data, q1[i].first, q1[i].last, q1[i].cyc, 10 + i, i == 0, i == 7, c_last + 3 + i);
            end
        end
    endtask

    task automatic test_gaps;
        int c_last;
        q1.delete(); q2.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'(i));
            if (i == 2 || i == 5) repeat (3) step(1'b0, 1'b1, 16'hBEEF);
        end
        c_last = cyc;
        idle(12);
        checks++;
        if (q1.size() !== 8) begin errors++; $display("FAIL gaps_count: got %0d want 8", q1.size()); end
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            checks++;
            if (q1[i].data !== 16'(br[i]) || q1[i].first !== (i == 0) || q1[i].last !== (i == 7) || q1[i].cyc !== c_last + 3 + i) begin
                errors++;
                $display("FAIL gaps[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q1[i].data, q1[i].first, q1[i].last, q1[i].cyc, br[i], i == 0, i == 7, c_last + 3 + i);
            end
        end
    endtask

    task automatic test_back_to_back;
        int c_last;
        int exp_d;
        q1.delete(); q2.delete();
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 16'(i));
        c_last = cyc;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b0, 16'hDEAD);
            checks++;
            if (b1 !== (cyc <= c_last + 10)) begin
                errors++;
                $display("FAIL b2b_busy cyc+%0d: got %b want %b", cyc - c_last, b1, cyc <= c_last + 10);
            end
        end
        checks++;
        if (q1.size() !== 24) begin errors++; $display("FAIL b2b_count: got %0d want 24", q1.size()); end
        for (int i = 0; i < 24 && i < q1.size(); i++) begin
            exp_d = 8 * (i / 8) + br[i % 8];
            checks++;
            if (q1[i].data !== 16'(exp_d) || q1[i].first !== (i % 8 == 0) || q1[i].last !== (i % 8 == 7) || q1[i].cyc !== c_last - 13 + i) begin
                errors++;
                $display("FAIL b2b[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q1[i].data, q1[i].first, q1[i].last, q1[i].cyc, exp_d, i % 8 == 0, i % 8 == 7, c_last - 13 + i);
            end
        end
    endtask

    task automatic test_reset_midop;
        int c_last;
        q1.delete(); q2.delete();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 16'(16'h0200 + i));
        start = 1'b0;
        checks++;
        if (v1 !== 1'b1) begin errors++; $display("FAIL midop_draining: got valid %b want 1", v1); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({so1, v1, f1, l1, b1} !== 20'd0) begin
            errors++;
            $display("FAIL midop_async_reset: got d=%0d v=%b f=%b l=%b busy=%b want all 0", so1, v1, f1, l1, b1);
        end
        checks++;
        if ({so2, v2, f2, l2, b2} !== 20'd0) begin
            errors++;
            $display("FAIL midop_async_reset_dut2: got d=%0d v=%b busy=%b want all 0", so2, v2, b2);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        q1.delete(); q2.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(100 + i));
        c_last = cyc;
        idle(12);
        checks++;
        if (q1.size() !== 8) begin errors++; $display("FAIL midop_count: got %0d want 8", q1.size()); end
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            checks++;
            if (q1[i].data !== 16'(100 + br[i]) || q1[i].first !== (i == 0) || q1[i].last !== (i == 7) || q1[i].cyc !== c_last + 3 + i) begin
                errors++;
                $display("FAIL midop[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q1[i].data, q1[i].first, q1[i].last, q1[i].cyc, 100 + br[i], i == 0, i == 7, c_last + 3 + i);
            end
        end
    endtask

    task automatic test_delay2;
        int c_last;
        q1.delete(); q2.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(40 + i));
        c_last = cyc;
        idle(12);
        checks++;
        if (q2.size() !== 8) begin errors++; $display("FAIL delay2_count: got %0d want 8", q2.size()); end
        for (int i = 0; i < 8 && i < q2.size(); i++) begin
            checks++;
            if (q2[i].data !== 16'(40 + br[i]) || q2[i].first !== (i == 0) || q2[i].last !== (i == 7) || q2[i].cyc !== c_last + 4 + i) begin
                errors++;
                $display("FAIL delay2[%0d]: got d=%0d f=%b l=%b cyc=%0d want d=%0d f=%b l=%b cyc=%0d",
                         i, q2[i].data, q2[i].first, q2[i].last, q2[i].cyc, 40 + br[i], i == 0, i == 7, c_last + 4 + i);
            end
        end
        checks++;
        if (q1.size() !== 8 || (q1.size() > 0 && q1[0].cyc !== c_last + 3)) begin
            errors++;
            $display("FAIL delay1_reference: got count=%0d want 8 starting at cyc %0d", q1.size(), c_last + 3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        bypass   = 1'b0;
        stage_in = '0;
        #12;
        test_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        test_reorder();
        test_bypass();
        test_gaps();
        test_back_to_back();
        test_reset_midop();
        test_delay2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
